// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Round-robin arbiter and issue controller for a shared 32-bit
//   combinational ALU. Two requesters are served over valid/ready
//   handshakes. The ALU result is captured into a one-entry response
//   register. Latency is one cycle and one operation can issue per cycle.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   reqN_valid / reqN_ready      requester N handshake (N = 0, 1)
//   reqN_op, reqN_a, reqN_b      requester N opcode and operands
//   reqN_id                      requester N transaction tag
//   alu_r1, alu_r2, alu_sub      ALU operand and opcode drive
//   alu_enable                   ALU enable, high only while issuing
//   alu_sum, alu_overflow        ALU result and overflow flag
//   rsp_valid / rsp_ready        response handshake
//   rsp_src, rsp_id              issuing requester index and echoed tag
//   rsp_result, rsp_overflow     captured ALU result and overflow flag
//   ops_count                    issued-operation counter, wraps at 2^16
module alu_arbiter #(
  parameter int unsigned ID_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [2:0]      req0_op,
  input  logic [31:0]     req0_a,
  input  logic [31:0]     req0_b,
  input  logic [ID_W-1:0] req0_id,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [2:0]      req1_op,
  input  logic [31:0]     req1_a,
  input  logic [31:0]     req1_b,
  input  logic [ID_W-1:0] req1_id,
  output logic [31:0]     alu_r1,
  output logic [31:0]     alu_r2,
  output logic [2:0]      alu_sub,
  output logic            alu_enable,
  input  logic [31:0]     alu_sum,
  input  logic            alu_overflow,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_src,
  output logic [ID_W-1:0] rsp_id,
  output logic [31:0]     rsp_result,
  output logic            rsp_overflow,
  output logic [15:0]     ops_count
);

  logic last;
  logic can_issue;
  logic fire0;
  logic fire1;
  logic issue;

  // A port's ready looks only at the other port's valid: port 0 may take
  // the slot unless port 1 is also asking and port 0 went last, and vice
  // versa. When both are valid exactly one ready is high.
  always_comb begin
    can_issue  = !rsp_valid || rsp_ready;
    req0_ready = rst_n && can_issue && (!req1_valid || last);
    req1_ready = rst_n && can_issue && (!req0_valid || !last);
    fire0      = req0_valid && req0_ready;
    fire1      = req1_valid && req1_ready;
    issue      = fire0 || fire1;
  end

  // ALU inputs are forced to zero unless an operation is issuing.
  always_comb begin
    alu_enable = 1'b0;
    alu_r1     = '0;
    alu_r2     = '0;
    alu_sub    = '0;
    if (fire1) begin
      alu_enable = 1'b1;
      alu_r1     = req1_a;
      alu_r2     = req1_b;
      alu_sub    = req1_op;
    end else if (fire0) begin
      alu_enable = 1'b1;
      alu_r1     = req0_a;
      alu_r2     = req0_b;
      alu_sub    = req0_op;
    end
  end

  // Issue and drain can share an edge: the new result overwrites the
  // drained one and rsp_valid stays high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid    <= 1'b0;
      rsp_result   <= '0;
      rsp_overflow <= 1'b0;
      rsp_id       <= '0;
      rsp_src      <= 1'b0;
      ops_count    <= '0;
      last         <= 1'b1;
    end else if (issue) begin
      rsp_valid    <= 1'b1;
      rsp_result   <= alu_sum;
      rsp_overflow <= alu_overflow;
      rsp_id       <= fire1 ? req1_id : req0_id;
      rsp_src      <= fire1;
      last         <= fire1;
      ops_count    <= ops_count + 16'd1;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
//   Directed self-checking bench for alu_arbiter. A small behavioural ALU
//   model drives alu_sum/alu_overflow from the DUT's ALU outputs. Inputs
//   change 1 time unit after the rising edge. Checks run 1 time unit
//   after the inputs change, or 1 time unit after an edge.
module tb_alu_arbiter;

  localparam int unsigned ID_W = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req0_valid, req1_valid;
  logic            req0_ready, req1_ready;
  logic [2:0]      req0_op, req1_op;
  logic [31:0]     req0_a, req0_b, req1_a, req1_b;
  logic [ID_W-1:0] req0_id, req1_id;
  logic [31:0]     alu_r1, alu_r2;
  logic [2:0]      alu_sub;
  logic            alu_enable;
  logic [31:0]     alu_sum;
  logic            alu_overflow;
  logic            rsp_valid, rsp_ready, rsp_src, rsp_overflow;
  logic [ID_W-1:0] rsp_id;
  logic [31:0]     rsp_result;
  logic [15:0]     ops_count;

  int unsigned compared   = 0;
  int unsigned mismatched = 0;
  logic [15:0] exp_ops    = '0;

  alu_arbiter #(.ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_id(req0_id),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_id(req1_id),
    .alu_r1(alu_r1), .alu_r2(alu_r2), .alu_sub(alu_sub),
    .alu_enable(alu_enable), .alu_sum(alu_sum), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_src(rsp_src),
    .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_overflow(rsp_overflow),
    .ops_count(ops_count)
  );

  always #5 clk = ~clk;

  // Behavioural model of the shared ALU
  always_comb begin
    alu_sum      = '0;
    alu_overflow = 1'b0;
    case (alu_sub)
      3'b000: begin
        alu_sum      = alu_r1 + alu_r2;
        alu_overflow = (alu_r1[31] == alu_r2[31]) && (alu_sum[31] != alu_r1[31]);
      end
      3'b001: begin
        alu_sum      = alu_r1 - alu_r2;
        alu_overflow = (alu_r1[31] != alu_r2[31]) && (alu_sum[31] != alu_r1[31]);
      end
      3'b010:  alu_sum = ~alu_r1;
      3'b011:  alu_sum = alu_r1 & alu_r2;
      3'b100:  alu_sum = alu_r1 | alu_r2;
      3'b101:  alu_sum = alu_r1 ^ alu_r2;
      3'b110:  alu_sum = {31'd0, $signed(alu_r1) < $signed(alu_r2)};
      default: alu_sum = {31'd0, alu_r1 == alu_r2};
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation from a lone requester and check the response.
  task automatic issue_one(input int src, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [ID_W-1:0] id,
                           input logic [31:0] exp_res, input logic exp_ovf);
    rsp_ready = 1'b1;
    if (src == 0) begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; req0_id = id;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; req1_id = id;
    end
    #1;
    chk("issue_ready", (src == 0) ? req0_ready : req1_ready, 1);
    chk("issue_alu_en", alu_enable, 1);
    chk("issue_alu_r1", alu_r1, a);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    exp_ops++;
    chk("issue_rsp_valid", rsp_valid, 1);
    chk("issue_rsp_result", rsp_result, exp_res);
    chk("issue_rsp_ovf", rsp_overflow, exp_ovf);
    chk("issue_rsp_src", rsp_src, src);
    chk("issue_rsp_id", rsp_id, id);
    chk("issue_ops", ops_count, exp_ops);
  endtask

  initial begin
    logic [ID_W-1:0] id0, id1, held_id;
    int              n;

    // Reset with a request pending: readies and ALU enable stay low
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_op = '0; req0_a = 32'd1; req0_b = 32'd1; req0_id = '0;
    req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0; req1_id = '0;
    rsp_ready = 1'b0;
    #12;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_src", rsp_src, 0);
    chk("rst_ops", ops_count, 0);
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_alu_en", alu_enable, 0);
    req0_valid = 1'b0;
    tick();
    rst_n = 1'b1;

    // Single issue and flag cases; the last one from req1 leaves last=1
    issue_one(0, 3'b000, 32'd5, 32'd7, 4'd3, 32'd12, 1'b0);
    issue_one(0, 3'b000, 32'h7FFF_FFFF, 32'd1, 4'd4, 32'h8000_0000, 1'b1);
    issue_one(0, 3'b110, 32'hFFFF_FFFF, 32'd1, 4'd5, 32'd1, 1'b0);
    issue_one(1, 3'b111, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 4'd6, 32'd1, 1'b0);

    // Contention: both valid for 6 cycles, grants alternate starting at 0
    id0 = 4'd0;
    id1 = 4'd8;
    rsp_ready  = 1'b1;
    req0_valid = 1'b1; req0_op = 3'b000; req0_a = 32'd10; req0_b = 32'd20; req0_id = id0;
    req1_valid = 1'b1; req1_op = 3'b001; req1_a = 32'd50; req1_b = 32'd8;  req1_id = id1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("cont_req0_ready", req0_ready, (k % 2 == 0) ? 1 : 0);
      chk("cont_req1_ready", req1_ready, (k % 2 == 0) ? 0 : 1);
      tick();
      exp_ops++;
      chk("cont_rsp_valid", rsp_valid, 1);
      chk("cont_rsp_src", rsp_src, k % 2);
      chk("cont_rsp_id", rsp_id, (k % 2 == 0) ? id0 : id1);
      chk("cont_rsp_result", rsp_result, (k % 2 == 0) ? 32'd30 : 32'd42);
      if (k % 2 == 0) begin
        id0++;
        req0_id = id0;
      end else begin
        held_id = id1;
        id1++;
        req1_id = id1;
      end
    end
    chk("cont_ops", ops_count, exp_ops);

    // Backpressure: a response is pending and req1 is waiting
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_op = 3'b100; req1_a = 32'hF0; req1_b = 32'h0F; req1_id = 4'hC;
    rsp_ready  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("bp_req1_ready", req1_ready, 0);
      chk("bp_alu_en", alu_enable, 0);
      tick();
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_src", rsp_src, 1);
      chk("bp_rsp_result", rsp_result, 32'd42);
      chk("bp_rsp_id", rsp_id, held_id);
      chk("bp_ops", ops_count, exp_ops);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", req1_ready, 1);
    chk("bp_release_alu_en", alu_enable, 1);
    tick();
    req1_valid = 1'b0;
    exp_ops++;
    chk("bp_issue_src", rsp_src, 1);
    chk("bp_issue_result", rsp_result, 32'hFF);
    chk("bp_issue_id", rsp_id, 4'hC);
    chk("bp_issue_ops", ops_count, exp_ops);

    // Counter wrap: run up to 0xFFFF issues, then one more
    req0_valid = 1'b1; req0_op = 3'b011; req0_a = 32'hFF; req0_b = 32'h0F; req0_id = 4'd1;
    n = 32'hFFFF - int'(exp_ops);
    repeat (n) begin
      tick();
      exp_ops++;
    end
    chk("wrap_ops_max", ops_count, 32'hFFFF);
    tick();
    exp_ops++;
    chk("wrap_ops_zero", ops_count, 32'h0000);
    chk("wrap_rsp_result", rsp_result, 32'h0F);

    // Idle: no requests, ALU drive is all zero and the response drains
    req0_valid = 1'b0;
    #1;
    chk("idle_alu_en", alu_enable, 0);
    chk("idle_alu_r1", alu_r1, 0);
    chk("idle_alu_r2", alu_r2, 0);
    chk("idle_alu_sub", alu_sub, 0);
    tick();
    chk("idle_rsp_drained", rsp_valid, 0);

    // Reset mid-operation with a response pending
    issue_one(0, 3'b101, 32'hFF00, 32'h0FF0, 4'd9, 32'hF0F0, 1'b0);
    rsp_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    exp_ops = '0;
    #1;
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_result", rsp_result, 0);
    chk("mid_rst_id", rsp_id, 0);
    chk("mid_rst_ops", ops_count, exp_ops);
    tick();
    rst_n = 1'b1;
    rsp_ready  = 1'b1;
    req0_valid = 1'b1; req0_op = 3'b000; req0_a = 32'd1; req0_b = 32'd2; req0_id = 4'd2;
    req1_valid = 1'b1; req1_op = 3'b000; req1_a = 32'd3; req1_b = 32'd4; req1_id = 4'd7;
    #1;
    chk("post_rst_req0_ready", req0_ready, 1);
    chk("post_rst_req1_ready", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    exp_ops++;
    chk("post_rst_src", rsp_src, 0);
    chk("post_rst_id", rsp_id, 4'd2);
    chk("post_rst_result", rsp_result, 32'd3);
    chk("post_rst_ops", ops_count, exp_ops);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and issue controller for the shared 32-bit combinational ALU. It drives the ALU operand, opcode and enable inputs and captures the ALU result into a one-entry registered response stage. Requesters are served round-robin over valid/ready handshakes, with one-cycle latency and a sustainable throughput of one operation per cycle. Typical clients are the execute unit (requester 0) and the branch-compare unit (requester 1).

## Interface
- `ID_W`, default 4: width of the requester-supplied transaction tag.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req0_valid` in 1: requester 0 has an operation.
- `req0_ready` out 1: requester 0 operation accepted this cycle.
- `req0_op` in 3: ALU opcode.
  - 000 add, 001 sub, 010 not r1, 011 and, 100 or, 101 xor, 110 signed less-than, 111 equal.
- `req0_a`, `req0_b` in 32: operands.
- `req0_id` in ID_W: tag.
- `req1_valid`, `req1_ready`, `req1_op`, `req1_a`, `req1_b`, `req1_id`: same as requester 0.
- `alu_r1`, `alu_r2` out 32: ALU operands.
- `alu_sub` out 3: ALU opcode.
- `alu_enable` out 1: ALU enable.
- `alu_sum` in 32: ALU result.
- `alu_overflow` in 1: ALU overflow flag.
- `rsp_valid` out 1: response register holds a result.
- `rsp_ready` in 1: consumer takes the response.
- `rsp_src` out 1: requester index that issued the result.
- `rsp_id` out ID_W: echoed tag.
- `rsp_result` out 32: captured `alu_sum`.
- `rsp_overflow` out 1: captured `alu_overflow`.
- `ops_count` out 16: number of issued operations; wraps modulo 2^16.

## Operation
- `can_issue` = !rsp_valid || rsp_ready.
- Arbitration is combinational and applies only when `can_issue` is 1.
  - Exactly one valid requester: that requester wins.
  - Both valid: the requester not equal to `last` wins.
  - `last` is a 1-bit register; reset value is 1, so requester 0 wins the first tie.
- Handshakes:
  - `reqN_ready` is 1 only for the winner in the issuing cycle; otherwise 0.
  - `reqN_ready` never depends on `reqN_valid` of the same port. It may depend on the other port's valid and on `rsp_ready`.
  - A requester holds valid and payload stable until ready.
- ALU drive:
  - While issuing: `alu_enable`=1, and `alu_r1`/`alu_r2`/`alu_sub` come from the winner.
  - Otherwise: `alu_enable`=0 and all operand/opcode outputs are 0.
- Issue edge:
  - `rsp_valid` <= 1.
  - `rsp_result` <= `alu_sum`, `rsp_overflow` <= `alu_overflow`.
  - `rsp_id` <= winner id, `rsp_src` <= winner index.
  - `last` <= winner index.
  - `ops_count` <= `ops_count`+1 (0xFFFF wraps to 0x0000).
- No issue, and `rsp_valid && rsp_ready`: `rsp_valid` <= 0. Data registers hold their last values.
- No issue, and `rsp_ready`=0: all registers hold.
- Simultaneous drain and issue: the new result replaces the old one in the same edge; `rsp_valid` stays 1.
- No request is ever dropped or duplicated. Result ordering equals grant ordering.

## Timing
- Reset (async assert, sync-to-clk deassert by the system): `rsp_valid`=0, `rsp_result`=0, `rsp_overflow`=0, `rsp_id`=0, `rsp_src`=0, `ops_count`=0, `last`=1.
  - Combinational outputs during reset: `req*_ready`=0, `alu_enable`=0.
- Latency: a request accepted in cycle T produces `rsp_valid`=1 in cycle T+1.
- Throughput: with `rsp_ready` tied to 1 and both requesters valid, grants alternate 0,1,0,1 with one issue per cycle.
- Backpressure: while `rsp_valid`=1 and `rsp_ready`=0, both readies are 0 and all `rsp_*` outputs are stable.
- Reset mid-operation: a pending response is discarded; nothing is replayed after reset.
- The ALU path (mux to ALU to response register) is a single-cycle combinational path.

## Test plan
- Single issue: req0 add a=5 b=7 id=3, `rsp_ready`=1.
  - Expect `req0_ready`=1 in cycle T; in T+1, `rsp_valid`=1, `rsp_result`=12, `rsp_src`=0, `rsp_id`=3, `ops_count`=1.
- Overflow and compare flags:
  - add 0x7FFFFFFF+1: expect `rsp_result`=0x80000000, `rsp_overflow`=1.
  - op 110 with a=0xFFFFFFFF, b=1: expect `rsp_result`=1.
  - op 111 with a=b=0xA5A5A5A5: expect `rsp_result`=1.
- Contention: both requesters valid continuously for 6 cycles, `rsp_ready`=1.
  - Expect `rsp_src` sequence 0,1,0,1,0,1 with no idle cycles, and `ops_count`=6.
- Backpressure: hold `rsp_ready`=0 for 4 cycles with a response pending and req1 valid.
  - Expect `req1_ready`=0 throughout, `rsp_*` stable, and `alu_enable`=0.
  - On `rsp_ready`=1, req1 issues in that same cycle.
- Wrap and idle: preload 0xFFFF issues, then issue 1 more.
  - Expect `ops_count`=0x0000.
  - With no requests, expect `alu_enable`=0 and `alu_r1`/`alu_r2`/`alu_sub`=0.
- Reset mid-operation: assert `rst_n`=0 while `rsp_valid`=1.
  - Expect immediate `rsp_valid`=0 and all reset values.
  - After release, a tie is won by requester 0.
